farrow_delay_loader: RTL
========================

Name: farrow_delay_loader

Overview:
- Parametrised delay-coefficient loader for the Farrow beamformer, clocked on clk_del.
- Accepts a streamed frame of N_CH×N_DN delay words, channel-major within each beam (ch fastest). Writes each word to the shadow bank of the addressed beam's coefficient store.
- Validates frame length against s_last and commits by atomically swapping active/shadow banks.
- Adds over the previous loader: valid/ready backpressure, double buffering, short/long frame detection with flush, commit hold, and a commit counter.

Parameters:
- DATA_W, 18, delay word width
- N_CH, 32, channels per beam (≥1)
- N_DN, 18, number of beams (≥1)
- CNT_W, 16, width of frame_cnt

Ports:
- clk_del  in  1  coefficient clock
- rst  in  1  synchronous, active-high reset
- s_vld  in  1  input word valid
- s_last  in  1  final word of frame
- s_data  in  DATA_W  delay word
- s_ready  out  1  loader can accept; beat accepted when s_vld&s_ready
- swap_hold  in  1  downstream not ready for bank swap; defers commit
- wr_en  out  N_DN  one-hot beam write strobe
- wr_addr  out  max(1,$clog2(N_CH))  channel index
- wr_data  out  DATA_W  word to write
- wr_bank  out  1  bank being written (= ~act_bank)
- act_bank  out  1  bank read by the datapath
- swap_pulse  out  1  one-cycle pulse on bank swap
- err_short  out  1  one-cycle pulse: s_last before N_CH*N_DN words
- err_long  out  1  one-cycle pulse: no s_last on word N_CH*N_DN
- frame_cnt  out  CNT_W  count of successful commits, wraps

Behaviour:
- Clock clk_del; reset rst, synchronous, active-high. All outputs registered.
- Reset values:
  - state=LOAD, ch=0, dn=0
  - s_ready=1 (from first cycle after reset)
  - wr_en=0, wr_addr=0, wr_data=0
  - act_bank=0, wr_bank=1
  - swap_pulse=0, err_short=0, err_long=0, frame_cnt=0
- Counters: ch counts 0..N_CH-1. On ch wrap, dn increments 0..N_DN-1. "Final position" is ch=N_CH-1 & dn=N_DN-1.
- Write latency 1: beat accepted at edge k produces wr_en[dn]=1, wr_addr=ch, wr_data=s_data for the cycle after edge k. wr_en is 0 on all other cycles.
- State LOAD (s_ready=1), per accepted beat: write the word, then:
  - s_last & final position → COMMIT; counters reset.
  - s_last & not final → err_short pulse; counters reset; stay LOAD; no swap. The shadow bank is partially overwritten; act_bank is unchanged.
  - !s_last & final → err_long pulse; counters reset; → FLUSH.
  - Otherwise advance counters.
- State COMMIT (s_ready=0):
  - If swap_hold=0: act_bank toggles, swap_pulse=1 for one cycle, frame_cnt+1 (wraps at 2^CNT_W), → LOAD.
  - If swap_hold=1: remain in COMMIT; no state change.
  - Minimum frame-to-frame gap is 1 cycle.
- State FLUSH (s_ready=1): beats accepted but discarded; wr_en=0. Accepted beat with s_last → LOAD, with no error pulse.
- s_vld while s_ready=0: not accepted. The source holds data, and counters do not move.
- err_short and err_long are never asserted in the same cycle. swap_pulse never coincides with an error pulse.
- Degenerate sizes:
  - N_CH=1 or N_DN=1 must work; wr_addr is then constant 0.
  - N_CH=N_DN=1: every beat is the final position.
- Reset mid-frame or mid-COMMIT: reset values are restored, the pending swap is discarded, and act_bank returns to 0.

Test Plan (N_CH=4, N_DN=3, DATA_W=18, CNT_W=16):
- Reset, then 12 beats data=0..11, s_last on beat 11, swap_hold=0:
  - wr_en=001 for words 0–3, 010 for 4–7, 100 for 8–11, with wr_addr 0..3 and wr_bank=1.
  - swap_pulse 1 cycle after the last write; act_bank=1, frame_cnt=1.
- 5 beats with s_last on beat 4 → err_short pulse; act_bank unchanged. A following full 12-beat frame then commits normally with beat 0 at dn=0, ch=0.
- 12 beats with no s_last, then 3 extra beats with s_last on the third:
  - err_long pulses after beat 11; the extra beats give wr_en=0.
  - No swap occurs, and the next frame starts at ch=0.
- Full frame with swap_hold=1 for 5 cycles after the final beat:
  - s_ready=0 and state stays COMMIT throughout.
  - swap_pulse appears the cycle after swap_hold falls.
- Random s_vld gaps combined with s_vld held high during COMMIT → no beat is lost or duplicated; the write sequence is identical to scenario 1.
- Reset asserted after beat 6 of a frame → all outputs return to reset values; a fresh 12-beat frame commits and act_bank=1.

Source files
------------

// File: rtl/farrow_delay_loader.sv
// Delay-coefficient loader for the Farrow beamformer: streams a channel-major frame
// into the shadow coefficient bank, validates frame length and swaps banks on commit.
module farrow_delay_loader #(
    parameter int DATA_W = 18,
    parameter int N_CH   = 32,
    parameter int N_DN   = 18,
    parameter int CNT_W  = 16,
    localparam int AW    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int DW    = (N_DN > 1) ? $clog2(N_DN) : 1
) (
    input  logic              clk_del,
    input  logic              rst,
    input  logic              s_vld,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              swap_hold,
    output logic [N_DN-1:0]   wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              act_bank,
    output logic              swap_pulse,
    output logic              err_short,
    output logic              err_long,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_COMMIT = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    localparam logic [AW-1:0] CH_LAST = AW'(N_CH - 1);
    localparam logic [DW-1:0] DN_LAST = DW'(N_DN - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       ch_q, ch_d;
    logic [DW-1:0]       dn_q, dn_d;
    logic                s_ready_q, s_ready_d;
    logic [N_DN-1:0]     wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                act_bank_q, act_bank_d;
    logic                wr_bank_q, wr_bank_d;
    logic                swap_pulse_q, swap_pulse_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic acc;
    logic final_pos;

    assign acc       = s_vld & s_ready_q;
    assign final_pos = (ch_q == CH_LAST) && (dn_q == DN_LAST);

    always_ff @(posedge clk_del) begin
        if (rst) begin
            state_q      <= S_LOAD;
            ch_q         <= '0;
            dn_q         <= '0;
            s_ready_q    <= 1'b1;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            act_bank_q   <= 1'b0;
            wr_bank_q    <= 1'b1;
            swap_pulse_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            dn_q         <= dn_d;
            s_ready_q    <= s_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            act_bank_q   <= act_bank_d;
            wr_bank_q    <= wr_bank_d;
            swap_pulse_q <= swap_pulse_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Any s_last or reaching the final position ends the frame and rewinds the counters.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dn_d    = dn_q;
        case (state_q)
            S_LOAD: begin
                if (acc) begin
                    if (s_last || final_pos) begin
                        ch_d = '0;
                        dn_d = '0;
                        if (s_last && final_pos) begin
                            state_d = S_COMMIT;
                        end else if (!s_last) begin
                            state_d = S_FLUSH;
                        end
                    end else if (ch_q == CH_LAST) begin
                        ch_d = '0;
                        dn_d = dn_q + DW'(1);
                    end else begin
                        ch_d = ch_q + AW'(1);
                    end
                end
            end
            S_COMMIT: begin
                if (!swap_hold) begin
                    state_d = S_LOAD;
                end
            end
            S_FLUSH: begin
                if (acc && s_last) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
                ch_d    = '0;
                dn_d    = '0;
            end
        endcase
    end

    always_comb begin
        s_ready_d    = (state_d != S_COMMIT);
        wr_en_d      = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        act_bank_d   = act_bank_q;
        swap_pulse_d = 1'b0;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            S_LOAD: begin
                if (acc) begin
                    for (int i = 0; i < N_DN; i++) begin
                        wr_en_d[i] = (dn_q == DW'(i));
                    end
                    wr_addr_d   = ch_q;
                    wr_data_d   = s_data;
                    err_short_d = s_last & ~final_pos;
                    err_long_d  = ~s_last & final_pos;
                end
            end
            S_COMMIT: begin
                if (!swap_hold) begin
                    act_bank_d   = ~act_bank_q;
                    swap_pulse_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
        wr_bank_d = ~act_bank_d;
    end

    assign s_ready    = s_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_bank    = wr_bank_q;
    assign act_bank   = act_bank_q;
    assign swap_pulse = swap_pulse_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
